// File: rtl/alt_cal_sequencer.sv
// ---------------------------------------------------------------------------
// alt_cal_sequencer
//
// Shares one calibration engine among NUM_CHANNELS transceiver channels.
// Requests are latched per channel and granted round-robin. For each grant
// the sequencer drives the channel's remap address, holds cal_start for
// START_CYCLES cycles, then follows the engine's busy rise and fall. Each
// phase has a timeout. One completion strobe is issued per grant. It carries
// the channel index and an error flag.
//
// Ports
//   clock          in   sole clock, all logic on posedge
//   reset          in   asynchronous active-high reset, clears all state
//   cal_req        in   per-channel request (pulse or level), latched
//   cal_start      out  start strobe to the calibration engine
//   cal_busy       in   busy indication from the calibration engine
//   cal_remap_addr out  logical channel address presented to the engine
//   done_valid     out  one-cycle completion strobe
//   done_chan      out  channel that completed, valid with done_valid
//   done_err       out  1 = the engine timed out, valid with done_valid
//   pending        out  latched requests that have not yet completed
//   seq_busy       out  1 while sequencing or while requests are pending
// ---------------------------------------------------------------------------
module alt_cal_sequencer #(
    parameter int          NUM_CHANNELS     = 4,
    parameter int          CHAN_IDX_WIDTH   = 2,
    parameter int          START_CYCLES     = 2,
    parameter int          RISE_TIMEOUT     = 16,
    parameter int          DONE_TIMEOUT     = 1024,
    parameter logic [11:0] PMA_BASE_ADDRESS = 12'h0,
    parameter logic [11:0] CHANNEL_STRIDE   = 12'h1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CHANNELS-1:0]   cal_req,
    output logic                      cal_start,
    input  logic                      cal_busy,
    output logic [11:0]               cal_remap_addr,
    output logic                      done_valid,
    output logic [CHAN_IDX_WIDTH-1:0] done_chan,
    output logic                      done_err,
    output logic [NUM_CHANNELS-1:0]   pending,
    output logic                      seq_busy
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_HI,
        WAIT_LO,
        REPORT
    } state_t;

    localparam logic [15:0] START_LAST = 16'(START_CYCLES);
    localparam logic [15:0] RISE_LAST  = 16'(RISE_TIMEOUT - 1);
    localparam logic [15:0] DONE_LAST  = 16'(DONE_TIMEOUT - 1);
    localparam logic [CHAN_IDX_WIDTH-1:0] LAST_CHAN = CHAN_IDX_WIDTH'(NUM_CHANNELS - 1);

    state_t                    state;
    logic [15:0]               timer;
    // Round-robin pointer. After a grant it also names the channel being
    // serviced. No separate grant register is kept.
    logic [CHAN_IDX_WIDTH-1:0] last;

    logic                      pick_found;
    logic [CHAN_IDX_WIDTH-1:0] pick_idx;
    logic [CHAN_IDX_WIDTH-1:0] cand_idx;
    logic [11:0]               pick_addr;
    logic [NUM_CHANNELS-1:0]   grant_mask;

    // Round-robin arbiter: the search starts at the channel after the last
    // grant and wraps to 0. The first pending channel in that order wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            cand_idx = CHAN_IDX_WIDTH'((int'(last) + k) % NUM_CHANNELS);
            if (!pick_found && pending[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
        pick_addr  = PMA_BASE_ADDRESS + 12'(pick_idx) * CHANNEL_STRIDE;
        grant_mask = NUM_CHANNELS'(1) << last;
    end

    // Sequencer. The timer is reused as the cal_start hold counter in LAUNCH.
    // It also counts the busy-rise and busy-fall timeouts in the two wait
    // states. New requests always OR into pending. When pending[g] is cleared
    // on leaving REPORT, a request for g arriving in that same cycle wins, so
    // g is queued for another service.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= '0;
            last           <= LAST_CHAN;
            pending        <= '0;
            cal_start      <= 1'b0;
            cal_remap_addr <= '0;
            done_valid     <= 1'b0;
            done_chan      <= '0;
            done_err       <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            pending    <= pending | cal_req;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        last           <= pick_idx;
                        timer          <= '0;
                        cal_remap_addr <= pick_addr;
                        state          <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (timer == START_LAST) begin
                        cal_start <= 1'b0;
                        timer     <= '0;
                        state     <= WAIT_HI;
                    end else begin
                        cal_start <= 1'b1;
                        timer     <= timer + 16'd1;
                    end
                end
                WAIT_HI: begin
                    if (cal_busy) begin
                        timer <= '0;
                        state <= WAIT_LO;
                    end else if (timer == RISE_LAST) begin
                        done_valid <= 1'b1;
                        done_chan  <= last;
                        done_err   <= 1'b1;
                        state      <= REPORT;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                WAIT_LO: begin
                    if (!cal_busy) begin
                        done_valid <= 1'b1;
                        done_chan  <= last;
                        done_err   <= 1'b0;
                        state      <= REPORT;
                    end else if (timer == DONE_LAST) begin
                        done_valid <= 1'b1;
                        done_chan  <= last;
                        done_err   <= 1'b1;
                        state      <= REPORT;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                REPORT: begin
                    pending <= (pending & ~grant_mask) | cal_req;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign seq_busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_alt_cal_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alt_cal_sequencer
//
// Directed self-checking bench for alt_cal_sequencer with default
// parameters. A small engine model drives cal_busy. In normal mode busy
// rises one cycle after start and is held for 50 cycles. The model can also
// be set to never assert busy, or to hold busy stuck high. Inputs are driven
// on the falling edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alt_cal_sequencer;

    localparam logic [1:0] ENG_NORMAL = 2'd0;
    localparam logic [1:0] ENG_NEVER  = 2'd1;
    localparam logic [1:0] ENG_STUCK  = 2'd2;

    logic        clock;
    logic        reset;
    logic [3:0]  cal_req;
    logic        cal_start;
    logic        cal_busy;
    logic [11:0] cal_remap_addr;
    logic        done_valid;
    logic [1:0]  done_chan;
    logic        done_err;
    logic [3:0]  pending;
    logic        seq_busy;

    logic [1:0]  eng_mode = ENG_NORMAL;
    logic [7:0]  hold_cnt;
    logic        start_q;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle_cnt    = 0;
    int done_count   = 0;

    alt_cal_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .cal_req        (cal_req),
        .cal_start      (cal_start),
        .cal_busy       (cal_busy),
        .cal_remap_addr (cal_remap_addr),
        .done_valid     (done_valid),
        .done_chan      (done_chan),
        .done_err       (done_err),
        .pending        (pending),
        .seq_busy       (seq_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    // Count every completion strobe. This catches extra or missing pulses.
    always @(negedge clock) if (done_valid === 1'b1) done_count <= done_count + 1;

    // Calibration engine model
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cal_busy <= 1'b0;
            hold_cnt <= '0;
            start_q  <= 1'b0;
        end else begin
            start_q <= cal_start;
            case (eng_mode)
                ENG_NEVER: cal_busy <= 1'b0;
                ENG_STUCK: cal_busy <= 1'b1;
                default: begin
                    if (cal_start && !start_q) begin
                        cal_busy <= 1'b1;
                        hold_cnt <= 8'd49;
                    end else if (hold_cnt != 0) begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end else begin
                        cal_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        cal_req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_req(input logic [3:0] mask);
        @(negedge clock);
        cal_req = mask;
        @(negedge clock);
        cal_req = '0;
    endtask

    task automatic wait_done(input int bound, output bit found, output logic [1:0] chan,
                             output logic err);
        found = 1'b0;
        chan  = 2'bxx;
        err   = 1'bx;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (done_valid === 1'b1) begin
                found = 1'b1;
                chan  = done_chan;
                err   = done_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        cal_req = '0;
        @(negedge clock);
        @(negedge clock);
        tests_run++;
        if (cal_start !== 1'b0 || done_valid !== 1'b0 || done_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes: got start=%b valid=%b err=%b expected 0 0 0",
                     cal_start, done_valid, done_err);
        end
        tests_run++;
        if (pending !== 4'b0000 || seq_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_pending: got pending=%b seq_busy=%b expected 0000 0",
                     pending, seq_busy);
        end
        tests_run++;
        if (cal_remap_addr !== 12'h000 || done_chan !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr: got addr=%h chan=%0d expected 000 0",
                     cal_remap_addr, done_chan);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit         found;
        logic [1:0] chan;
        logic       err;
        do_reset();
        eng_mode = ENG_NORMAL;
        @(negedge clock);
        cal_req = 4'b0100;
        @(negedge clock);
        cal_req = '0;
        tests_run++;
        if (pending !== 4'b0100 || cal_start !== 1'b0 || seq_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_latch: got pending=%b start=%b busy=%b expected 0100 0 1",
                     pending, cal_start, seq_busy);
        end
        @(negedge clock);
        tests_run++;
        if (cal_start !== 1'b0 || cal_remap_addr !== 12'h002) begin
            tests_failed++;
            $display("[TB] FAIL single_grant: got start=%b addr=%h expected 0 002",
                     cal_start, cal_remap_addr);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            tests_run++;
            if (cal_start !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL single_start_hi%0d: got %b expected 1", i, cal_start);
            end
        end
        @(negedge clock);
        tests_run++;
        if (cal_start !== 1'b0 || cal_remap_addr !== 12'h002) begin
            tests_failed++;
            $display("[TB] FAIL single_start_lo: got start=%b addr=%h expected 0 002",
                     cal_start, cal_remap_addr);
        end
        wait_done(200, found, chan, err);
        tests_run++;
        if (!found || chan !== 2'd2 || err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_done: got found=%0d chan=%0d err=%b expected 1 2 0",
                     found, chan, err);
        end
        @(negedge clock);
        tests_run++;
        if (done_valid !== 1'b0 || pending !== 4'b0000 || seq_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_after: got valid=%b pending=%b busy=%b expected 0 0000 0",
                     done_valid, pending, seq_busy);
        end
    endtask

    task automatic test_all_four();
        bit         found;
        logic [1:0] chan;
        logic       err;
        int         d0;
        do_reset();
        eng_mode = ENG_NORMAL;
        d0 = done_count;
        pulse_req(4'b1111);
        for (int i = 0; i < 4; i++) begin
            wait_done(200, found, chan, err);
            tests_run++;
            if (!found || chan !== 2'(i) || err !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL all_four_%0d: got found=%0d chan=%0d err=%b expected 1 %0d 0",
                         i, found, chan, err, i);
            end
        end
        repeat (100) @(negedge clock);
        tests_run++;
        if (done_count - d0 != 4 || pending !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL all_four_count: got pulses=%0d pending=%b expected 4 0000",
                     done_count - d0, pending);
        end
    endtask

    task automatic test_round_robin();
        bit         found;
        logic [1:0] chan;
        logic       err;
        logic [3:0] masks [6] = '{4'b0010, 4'b0011, 4'b0000, 4'b1000, 4'b1001, 4'b0000};
        logic [1:0] order [6] = '{2'd1, 2'd0, 2'd1, 2'd3, 2'd0, 2'd3};
        do_reset();
        eng_mode = ENG_NORMAL;
        for (int i = 0; i < 6; i++) begin
            if (masks[i] != 4'b0000) pulse_req(masks[i]);
            wait_done(200, found, chan, err);
            tests_run++;
            if (!found || chan !== order[i] || err !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rr_step%0d: got found=%0d chan=%0d err=%b expected 1 %0d 0",
                         i, found, chan, err, order[i]);
            end
        end
    endtask

    task automatic test_timeouts();
        bit         found;
        logic [1:0] chan;
        logic       err;
        int         t0;
        do_reset();
        eng_mode = ENG_NEVER;
        @(negedge clock);
        cal_req = 4'b0001;
        @(negedge clock);
        cal_req = '0;
        t0 = cycle_cnt;
        wait_done(100, found, chan, err);
        tests_run++;
        if (!found || chan !== 2'd0 || err !== 1'b1 || cycle_cnt - t0 != 20) begin
            tests_failed++;
            $display("[TB] FAIL rise_timeout: got found=%0d chan=%0d err=%b delay=%0d expected 1 0 1 20",
                     found, chan, err, cycle_cnt - t0);
        end
        @(negedge clock);
        tests_run++;
        if (done_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rise_timeout_pulse: got valid=%b expected 0", done_valid);
        end
        eng_mode = ENG_STUCK;
        @(negedge clock);
        cal_req = 4'b0010;
        @(negedge clock);
        cal_req = '0;
        t0 = cycle_cnt;
        wait_done(1200, found, chan, err);
        tests_run++;
        if (!found || chan !== 2'd1 || err !== 1'b1 || cycle_cnt - t0 != 1029) begin
            tests_failed++;
            $display("[TB] FAIL done_timeout: got found=%0d chan=%0d err=%b delay=%0d expected 1 1 1 1029",
                     found, chan, err, cycle_cnt - t0);
        end
        eng_mode = ENG_NORMAL;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        bit         found;
        logic [1:0] chan;
        logic       err;
        do_reset();
        eng_mode = ENG_NORMAL;
        pulse_req(4'b0010);
        wait_done(200, found, chan, err);
        tests_run++;
        if (!found || chan !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL requeue_first: got found=%0d chan=%0d expected 1 1", found, chan);
        end
        cal_req = 4'b0010;
        @(negedge clock);
        cal_req = '0;
        tests_run++;
        if (pending !== 4'b0010 || seq_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL requeue_pending: got pending=%b busy=%b expected 0010 1",
                     pending, seq_busy);
        end
        wait_done(200, found, chan, err);
        tests_run++;
        if (!found || chan !== 2'd1 || err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL requeue_second: got found=%0d chan=%0d err=%b expected 1 1 0",
                     found, chan, err);
        end
        @(negedge clock);
        tests_run++;
        if (pending !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL requeue_clear: got pending=%b expected 0000", pending);
        end
    endtask

    task automatic test_reset_mid();
        bit         found;
        logic [1:0] chan;
        logic       err;
        int         d0;
        do_reset();
        eng_mode = ENG_NORMAL;
        pulse_req(4'b0010);
        repeat (15) @(negedge clock);
        tests_run++;
        if (seq_busy !== 1'b1 || pending !== 4'b0010 || cal_remap_addr !== 12'h001) begin
            tests_failed++;
            $display("[TB] FAIL mid_before: got busy=%b pending=%b addr=%h expected 1 0010 001",
                     seq_busy, pending, cal_remap_addr);
        end
        d0 = done_count;
        reset = 1'b1;
        #1;
        tests_run++;
        if (cal_start !== 1'b0 || done_valid !== 1'b0 || pending !== 4'b0000 ||
            seq_busy !== 1'b0 || cal_remap_addr !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL mid_async: got start=%b valid=%b pending=%b busy=%b addr=%h expected 0 0 0000 0 000",
                     cal_start, done_valid, pending, seq_busy, cal_remap_addr);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (80) @(negedge clock);
        tests_run++;
        if (done_count != d0 || seq_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_no_done: got pulses=%0d busy=%b expected 0 0",
                     done_count - d0, seq_busy);
        end
        pulse_req(4'b1111);
        wait_done(200, found, chan, err);
        tests_run++;
        if (!found || chan !== 2'd0 || err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_restart: got found=%0d chan=%0d err=%b expected 1 0 0",
                     found, chan, err);
        end
    endtask

    // Safety net in case the sequencing stalls outside a bounded wait
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        cal_req = '0;
        test_reset();
        test_single();
        test_all_four();
        test_round_robin();
        test_timeouts();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
